// File: rtl/sysarray_drain.sv
// sysarray_drain: collects the NUM x NUM per-PE results of the systolic array
// as they trickle in (in any skewed order). Once every PE has reported, the
// tile is streamed out one row per beat over a valid/ready interface.
module sysarray_drain #(
    parameter int WL  = 32,
    parameter int NUM = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [WL*NUM*NUM-1:0]      resultvalue,
    input  logic [NUM*NUM-1:0]         resultvalid,
    output logic [WL*NUM-1:0]          rowvalue,
    output logic                       rowvalid,
    input  logic                       rowready,
    output logic [$clog2(NUM)-1:0]     rowindex,
    output logic                       rowlast,
    output logic                       busy,
    output logic                       overrun
);

    localparam int RW    = $clog2(NUM);
    localparam int CELLS = NUM * NUM;
    localparam logic [RW-1:0] LASTROW = RW'(NUM - 1);

    localparam logic COLLECT = 1'b0;
    localparam logic DRAIN   = 1'b1;

    logic                  state;
    logic [RW-1:0]         row;
    logic [CELLS-1:0]      got;
    logic [CELLS-1:0]      gotnext;
    logic [WL*CELLS-1:0]   buffer;
    logic                  transfer;
    logic                  capturing;

    // Capture flags as they would look once this cycle's pulses are included.
    always_comb begin
        gotnext   = got | resultvalid;
        capturing = ena && (state == COLLECT);
        transfer  = rowvalid && rowready && ena;
    end

    // Output view: the buffer is cleared on reset, so rowvalue reads zero then.
    always_comb begin
        rowvalid = (state == DRAIN);
        busy     = (state == DRAIN);
        rowindex = row;
        rowlast  = rowvalid && (row == LASTROW);
        rowvalue = buffer[int'(row)*NUM*WL +: NUM*WL];
    end

    // Tile buffer: each pulsing PE overwrites its word; only written while collecting.
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer <= '0;
        end else if (capturing) begin
            for (int k = 0; k < CELLS; k++) begin
                if (resultvalid[k]) begin
                    buffer[k*WL +: WL] <= resultvalue[k*WL +: WL];
                end
            end
        end
    end

    // Control: collect until every PE has reported, then drain rows on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            got     <= '0;
            row     <= '0;
            overrun <= 1'b0;
        end else if (ena) begin
            case (state)
                COLLECT: begin
                    got <= gotnext;
                    if (&gotnext) begin
                        state <= DRAIN;
                        row   <= '0;
                    end
                end
                DRAIN: begin
                    if (|resultvalid) begin
                        overrun <= 1'b1;
                    end
                    if (transfer) begin
                        if (row == LASTROW) begin
                            state <= COLLECT;
                            got   <= '0;
                            row   <= '0;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysarray_drain.sv
// tb_sysarray_drain: directed self-checking bench for sysarray_drain at
// NUM=4, WL=8, with expected rows built from a small tile model.
module tb_sysarray_drain;

    localparam int WL    = 8;
    localparam int NUM   = 4;
    localparam int CELLS = NUM * NUM;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ena;
    logic [WL*CELLS-1:0]    resultvalue;
    logic [CELLS-1:0]       resultvalid;
    logic [WL*NUM-1:0]      rowvalue;
    logic                   rowvalid;
    logic                   rowready;
    logic [1:0]             rowindex;
    logic                   rowlast;
    logic                   busy;
    logic                   overrun;

    logic [7:0] tile [CELLS];
    int checks = 0;
    int errors = 0;

    sysarray_drain #(.WL(WL), .NUM(NUM)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .resultvalue (resultvalue),
        .resultvalid (resultvalid),
        .rowvalue    (rowvalue),
        .rowvalid    (rowvalid),
        .rowready    (rowready),
        .rowindex    (rowindex),
        .rowlast     (rowlast),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [CELLS-1:0] valid);
        resultvalid = valid;
        tick();
        resultvalid = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rowexp(input int r);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < NUM; j++) v[j*WL +: WL] = tile[r*NUM + j];
        return v;
    endfunction

    task automatic setTile(input int base);
        for (int k = 0; k < CELLS; k++) begin
            tile[k] = 8'(base + k);
            resultvalue[k*WL +: WL] = 8'(base + k);
        end
    endtask

    task automatic checkRow(input int r);
        checkOutput("rowvalid", 32'(rowvalid), 32'd1);
        checkOutput("busy", 32'(busy), 32'd1);
        checkOutput("rowindex", 32'(rowindex), 32'(r));
        checkOutput("rowvalue", rowvalue, rowexp(r));
        checkOutput("rowlast", 32'(rowlast), 32'(r == NUM - 1));
    endtask

    task automatic drainFrom(input int r0);
        rowready = 1'b1;
        for (int r = r0; r < NUM; r++) begin
            checkRow(r);
            tick();
        end
        checkOutput("rowvalid_after_drain", 32'(rowvalid), 32'd0);
        checkOutput("busy_after_drain", 32'(busy), 32'd0);
    endtask

    // Directed sequence of scenarios.
    initial begin
        logic [CELLS-1:0] skew;
        rst = 1'b1; ena = 1'b1; rowready = 1'b0;
        resultvalue = '0; resultvalid = '0;
        tick(); tick();
        rst = 1'b0;

        checkOutput("reset_rowvalid", 32'(rowvalid), 32'd0);
        checkOutput("reset_rowvalue", rowvalue, 32'd0);
        checkOutput("reset_rowindex", 32'(rowindex), 32'd0);
        checkOutput("reset_rowlast", 32'(rowlast), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);

        // All results arrive in one cycle.
        rowready = 1'b1;
        setTile(0);
        applyStimulus('1);
        drainFrom(0);

        // Skewed arrival: PE(i,j) at cycle i+j.
        setTile(8'h40);
        for (int c = 0; c <= 6; c++) begin
            skew = '0;
            for (int i = 0; i < NUM; i++)
                for (int j = 0; j < NUM; j++)
                    if (i + j == c) skew[i*NUM + j] = 1'b1;
            applyStimulus(skew);
            checkOutput("skew_rowvalid", 32'(rowvalid), 32'(c == 6));
            checkOutput("skew_busy", 32'(busy), 32'(c == 6));
        end
        drainFrom(0);

        // Backpressure while row 1 is presented.
        setTile(8'h80);
        applyStimulus('1);
        checkRow(0);
        tick();
        rowready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checkRow(1);
        end
        rowready = 1'b1;
        tick();
        drainFrom(2);

        // Overrun: a pulse during drain is dropped and flagged.
        setTile(8'hC0);
        applyStimulus('1);
        rowready = 1'b0;
        resultvalue[3*WL +: WL] = 8'hFF;
        applyStimulus(16'h0008);
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        checkRow(0);
        drainFrom(0);
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);
        setTile(8'h10);
        applyStimulus('1);
        drainFrom(0);
        checkOutput("overrun_still", 32'(overrun), 32'd1);

        // Duplicate pulse: latest value wins, no overrun.
        rst = 1'b1; tick(); rst = 1'b0;
        setTile(8'h50);
        resultvalue[5*WL +: WL] = 8'h11;
        applyStimulus(16'h0020);
        resultvalue[5*WL +: WL] = 8'h22;
        applyStimulus(16'h0020);
        checkOutput("dup_busy", 32'(busy), 32'd0);
        tile[5] = 8'h22;
        applyStimulus(16'hFFDF);
        checkOutput("dup_overrun", 32'(overrun), 32'd0);
        drainFrom(0);

        // Reset mid-drain after the row-1 transfer.
        setTile(8'h60);
        applyStimulus('1);
        rowready = 1'b1;
        applyStimulus(16'h0001);
        checkRow(1);
        tick();
        checkOutput("pre_reset_overrun", 32'(overrun), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        checkOutput("rst_rowvalid", 32'(rowvalid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_rowvalue", rowvalue, 32'd0);

        // Fresh tile with a two-cycle enable gap mid-drain.
        setTile(8'h70);
        applyStimulus('1);
        checkRow(0); tick();
        checkRow(1); tick();
        ena = 1'b0;
        for (int n = 0; n < 2; n++) begin
            applyStimulus(16'h0001);
            checkRow(2);
            checkOutput("ena_overrun", 32'(overrun), 32'd0);
        end
        ena = 1'b1;
        drainFrom(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysarray_drain.md
# sysarray_drain

Result-collection block for the systolic GEMM array. Captures the NUM×NUM per-PE results as each PE's `resultvalid` pulses, in whatever skewed order they arrive. Once a full tile is held, streams it out one row (NUM words) per beat over a valid/ready interface. Sits directly on the array's `resultvalue`/`resultvalid` buses and feeds the write-back path.

## Interface

Parameters:

- `WL`, 32: bit width of one result word.
- `NUM`, 16: array dimension; NUM ≥ 2, power of two.

Ports:

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ena`  in  1  clock enable; when low, all state and outputs hold.
- `resultvalue`  in  WL*NUM*NUM  PE(i,j) word at bits [i*NUM*WL + j*WL +: WL].
- `resultvalid`  in  NUM*NUM  one-cycle pulse per PE; bit i*NUM+j.
- `rowvalue`  out  WL*NUM  current row; element j at [j*WL +: WL].
- `rowvalid`  out  1  row beat valid.
- `rowready`  in  1  downstream accepts beat.
- `rowindex`  out  $clog2(NUM)  row number of current beat.
- `rowlast`  out  1  current beat is row NUM-1.
- `busy`  out  1  high while draining; upstream must not start a new tile.
- `overrun`  out  1  sticky error: a result pulse was dropped.

## Operation

- Storage:
  - Tile buffer: NUM*NUM words.
  - `got`: NUM*NUM capture flags.
  - Row counter.
  - Sticky overrun flag.
- FSM states: COLLECT (reset state) and DRAIN.
- COLLECT, on each cycle with `ena`=1:
  - For every bit k with `resultvalid[k]`=1: buffer[k] ← word k and got[k] ← 1.
  - A repeated pulse for an already-captured PE overwrites its word; latest value wins, no error.
  - If `got`, including this cycle's captures, becomes all ones: next state DRAIN, row ← 0.
- DRAIN:
  - `rowvalid`=1; `rowvalue` = buffer row `rowindex`.
  - Transfer occurs when `rowvalid` & `rowready` & `ena`.
  - On transfer with row < NUM-1: row ← row+1.
  - On transfer with row = NUM-1: next state COLLECT, `got` ← 0, row ← 0.
  - Any `resultvalid` bit high in DRAIN with `ena`=1: pulse discarded, buffer unchanged, `overrun` ← 1.
  - This includes the final-transfer cycle; the pulse is not counted toward the next tile.
- Combinational outputs:
  - `busy` = (state == DRAIN).
  - `rowlast` = `rowvalid` & (row == NUM-1).
  - `rowindex` = row counter.
- `overrun` is cleared only by `rst`.
- `ena`=0:
  - No capture, no transfer, no state or counter change, no overrun update.
  - `resultvalid` pulses in that cycle are lost silently.
  - `rowvalid` stays at its current value.
- `rst`=1 (any state, including mid-drain):
  - Next cycle: state COLLECT, `got`=0, row=0, buffer=0, `overrun`=0.
  - Partial tile and undrained rows are discarded.

## Timing

- Reset values of outputs:
  - `rowvalid`=0, `rowvalue`=0, `rowindex`=0, `rowlast`=0, `busy`=0, `overrun`=0.
- Capture latency: the final `resultvalid` pulse of a tile at cycle t gives `rowvalid`=1 at cycle t+1.
- Drain throughput:
  - One row per cycle with `rowready` held high.
  - A full tile takes NUM cycles in DRAIN.
  - `rowvalid` falls the cycle after the `rowlast` transfer.
- Back-to-back tiles: the earliest capture for the next tile is the cycle after the final transfer.
- Handshake rules:
  - While `rowvalid`=1 and no transfer, `rowvalue`, `rowindex` and `rowlast` are stable.
  - `rowvalid` never drops without a transfer, except on `rst`.
  - `rowready` may change freely and does not combinationally affect `rowvalid`.
- `overrun` rises the cycle after the offending pulse.

## Test plan

All scenarios use NUM=4, WL=8; word k = PE bit index k.

- All 16 `resultvalid` bits high in one cycle t, word k = k, `rowready`=1 → `rowvalid` at t+1..t+4.
  - Row r element j = 4r+j; `rowindex` 0,1,2,3; `rowlast` only at t+4.
  - `busy` high for exactly 4 cycles.
- Skewed arrival, PE(i,j) pulses at cycle i+j → `busy`/`rowvalid` stay 0 through cycle 6, both rise at cycle 7.
  - Rows match the captured words.
- Backpressure: `rowready`=0 for 3 cycles while row 1 is presented → row 1 value and `rowindex`=1 held stable.
  - Transfer occurs on the cycle `rowready` returns; row 2 follows.
- Overrun: pulse on bit 3 during DRAIN → `overrun`=1 the next cycle and stays 1.
  - Drained rows are unchanged.
  - The following tile collects and drains correctly.
- Duplicate: bit 5 pulses 0x11, then 0x22, in COLLECT, then the rest complete → row 1 element 1 = 0x22; `overrun`=0.
- `rst` after the row-1 transfer → next cycle `rowvalid`=0, `busy`=0, `overrun`=0, `rowvalue`=0.
  - A new 16-pulse tile drains rows 0..3 correctly.
  - `ena`=0 for 2 cycles mid-drain freezes `rowindex` despite `rowready`=1.
